// File: rtl/au_issue_queue_if.sv
// Dispatch, CDB and AU-issue signal bundle for the load/store issue queue.
// The queue takes the slave view; dispatch, CDB and the AU together take the master view.
interface au_issue_queue_if;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_op;
  logic        disp_is_store;
  logic [2:0]  disp_rob;
  logic [31:0] disp_base;
  logic [2:0]  disp_base_tag;
  logic        disp_base_rdy;
  logic [31:0] disp_offset;
  logic [31:0] disp_data;
  logic [2:0]  disp_data_tag;
  logic        disp_data_rdy;

  logic        cdb_valid;
  logic [2:0]  cdb_rob;
  logic [31:0] cdb_value;

  logic        au_valid;
  logic        au_ready;
  logic [31:0] au_value1;
  logic [31:0] au_value2;
  logic [4:0]  au_op;
  logic [2:0]  au_rob;
  logic [31:0] au_ls_value;

  modport slave (
    input  disp_valid, disp_op, disp_is_store, disp_rob, disp_base, disp_base_tag,
           disp_base_rdy, disp_offset, disp_data, disp_data_tag, disp_data_rdy,
           cdb_valid, cdb_rob, cdb_value, au_ready,
    output disp_ready, au_valid, au_value1, au_value2, au_op, au_rob, au_ls_value
  );

  modport master (
    output disp_valid, disp_op, disp_is_store, disp_rob, disp_base, disp_base_tag,
           disp_base_rdy, disp_offset, disp_data, disp_data_tag, disp_data_rdy,
           cdb_valid, cdb_rob, cdb_value, au_ready,
    input  disp_ready, au_valid, au_value1, au_value2, au_op, au_rob, au_ls_value
  );
endinterface

// File: rtl/au_issue_queue.sv
// In-order load/store issue queue: holds micro-ops until base/store-data arrive on
// the CDB, then issues them one at a time, in program order, through a registered AU slot.
module au_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  au_issue_queue_if.slave   bus
);

  typedef struct packed {
    logic [4:0]  op;
    logic        is_store;
    logic [2:0]  rob;
    logic [31:0] base;
    logic [2:0]  base_tag;
    logic        base_rdy;
    logic [31:0] offset;
    logic [31:0] data;
    logic [2:0]  data_tag;
    logic        data_rdy;
  } entry_t;

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  entry_t             r_q [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;

  logic               r_au_valid;
  logic [31:0]        r_au_value1;
  logic [31:0]        r_au_value2;
  logic [4:0]         r_au_op;
  logic [2:0]         r_au_rob;
  logic [31:0]        r_au_ls_value;

  entry_t             w_head;
  entry_t             w_new;
  logic               w_head_rdy;
  logic               w_slot_free;
  logic               w_issue;
  logic               w_disp;
  logic               w_cdb_hit;

  assign bus.disp_ready = (r_count != FULL);
  assign w_disp         = bus.disp_valid && bus.disp_ready;
  assign w_cdb_hit      = bus.cdb_valid && (bus.cdb_rob != 3'd0);

  assign w_head      = r_q[r_head];
  assign w_head_rdy  = r_vld[r_head] && w_head.base_rdy && (!w_head.is_store || w_head.data_rdy);
  assign w_slot_free = !r_au_valid || bus.au_ready;
  assign w_issue     = w_head_rdy && w_slot_free;

  // New entry, with operands that match the same-cycle CDB broadcast captured as ready.
  always_comb begin
    w_new          = '0;
    w_new.op       = bus.disp_op;
    w_new.is_store = bus.disp_is_store;
    w_new.rob      = bus.disp_rob;
    w_new.offset   = bus.disp_offset;
    w_new.base_tag = bus.disp_base_tag;
    if (bus.disp_base_rdy) begin
      w_new.base     = bus.disp_base;
      w_new.base_rdy = 1'b1;
    end else if (w_cdb_hit && bus.cdb_rob == bus.disp_base_tag) begin
      w_new.base     = bus.cdb_value;
      w_new.base_rdy = 1'b1;
    end
    w_new.data_tag = bus.disp_data_tag;
    if (!bus.disp_is_store) begin
      w_new.data_rdy = 1'b1;
    end else if (bus.disp_data_rdy) begin
      w_new.data     = bus.disp_data;
      w_new.data_rdy = 1'b1;
    end else if (w_cdb_hit && bus.cdb_rob == bus.disp_data_tag) begin
      w_new.data     = bus.cdb_value;
      w_new.data_rdy = 1'b1;
    end
  end

  // NOTE: entry payload is deliberately left out of reset; the valid bits alone decide
  // whether an entry means anything, so resetting the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && w_cdb_hit) begin
        if (!r_q[i].base_rdy && r_q[i].base_tag == bus.cdb_rob) begin
          r_q[i].base     <= bus.cdb_value;
          r_q[i].base_rdy <= 1'b1;
        end
        if (!r_q[i].data_rdy && r_q[i].data_tag == bus.cdb_rob) begin
          r_q[i].data     <= bus.cdb_value;
          r_q[i].data_rdy <= 1'b1;
        end
      end
    end
    if (w_disp) r_q[r_tail] <= w_new;
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_disp) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PTR_ONE;
      end
      if (w_issue) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_ONE;
      end
      r_count <= r_count + {{PTR_W{1'b0}}, w_disp} - {{PTR_W{1'b0}}, w_issue};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_au_valid    <= 1'b0;
      r_au_value1   <= '0;
      r_au_value2   <= '0;
      r_au_op       <= '0;
      r_au_rob      <= '0;
      r_au_ls_value <= '0;
    end else if (w_issue) begin
      r_au_valid    <= 1'b1;
      r_au_value1   <= w_head.base;
      r_au_value2   <= w_head.offset;
      r_au_op       <= w_head.op;
      r_au_rob      <= w_head.rob;
      r_au_ls_value <= w_head.is_store ? w_head.data : 32'd0;
    end else if (r_au_valid && bus.au_ready) begin
      r_au_valid <= 1'b0;
      r_au_rob   <= '0;
    end
  end

  assign bus.au_valid    = r_au_valid;
  assign bus.au_value1   = r_au_value1;
  assign bus.au_value2   = r_au_value2;
  assign bus.au_op       = r_au_op;
  assign bus.au_rob      = r_au_rob;
  assign bus.au_ls_value = r_au_ls_value;

endmodule

// File: tb/tb_au_issue_queue.sv
// Directed bench for au_issue_queue: latency, CDB wakeup, ordering under full queue,
// backpressure, dispatch-cycle bypass and flush.
module tb_au_issue_queue;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_total = 0;
  int   n_pass  = 0;

  au_issue_queue_if bus ();

  au_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [2:0] rob, input logic st,
                      input logic [31:0] base, input logic [2:0] btag, input logic brdy,
                      input logic [31:0] off,
                      input logic [31:0] data, input logic [2:0] dtag, input logic drdy);
    bus.disp_valid    = 1'b1;
    bus.disp_op       = {st, 1'b0, rob};
    bus.disp_is_store = st;
    bus.disp_rob      = rob;
    bus.disp_base     = base;
    bus.disp_base_tag = btag;
    bus.disp_base_rdy = brdy;
    bus.disp_offset   = off;
    bus.disp_data     = data;
    bus.disp_data_tag = dtag;
    bus.disp_data_rdy = drdy;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_rob   = tag;
    bus.cdb_value = val;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_rob    = 3'd0;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    disp(3'd0, 1'b0, '0, 3'd0, 1'b0, '0, '0, 3'd0, 1'b0);
    idle();
    bus.cdb_value = '0;
    bus.au_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_au_valid", bus.au_valid, 0);
    check("rst_au_rob", bus.au_rob, 0);
    check("rst_au_value1", bus.au_value1, 0);
    check("rst_disp_ready", bus.disp_ready, 1);

    // Ready load: written at edge N, issued at edge N+1.
    disp(3'd3, 1'b0, 32'h100, 3'd0, 1'b1, 32'h8, 32'h0, 3'd0, 1'b0);
    tick();
    idle();
    check("ld_not_yet", bus.au_valid, 0);
    tick();
    check("ld_valid", bus.au_valid, 1);
    check("ld_value1", bus.au_value1, 32'h100);
    check("ld_value2", bus.au_value2, 32'h8);
    check("ld_rob", bus.au_rob, 3);
    check("ld_ls", bus.au_ls_value, 0);
    check("ld_op", bus.au_op, 5'h03);
    tick();
    check("ld_drain_valid", bus.au_valid, 0);
    check("ld_drain_rob", bus.au_rob, 0);

    // Store waiting on base tag 5.
    disp(3'd4, 1'b1, 32'h0, 3'd5, 1'b0, 32'h10, 32'hDEADBEEF, 3'd0, 1'b1);
    tick();
    idle();
    tick();
    check("st_wait", bus.au_valid, 0);
    cdb(3'd5, 32'h2000);
    tick();
    idle();
    check("st_woken_not_issued", bus.au_valid, 0);
    tick();
    check("st_valid", bus.au_valid, 1);
    check("st_value1", bus.au_value1, 32'h2000);
    check("st_value2", bus.au_value2, 32'h10);
    check("st_ls", bus.au_ls_value, 32'hDEADBEEF);
    check("st_rob", bus.au_rob, 4);
    tick();
    check("st_drain", bus.au_valid, 0);

    // Fill with non-ready loads rob1..4 (base tags 4..7); pointers wrap from 2.
    for (int k = 1; k <= 4; k++) begin
      disp(3'(k), 1'b0, 32'h0, 3'(k + 3), 1'b0, 32'(k), 32'h0, 3'd0, 1'b0);
      tick();
    end
    check("full_disp_ready", bus.disp_ready, 0);
    disp(3'd5, 1'b0, 32'h555, 3'd0, 1'b1, 32'h5, 32'h0, 3'd0, 1'b0);
    tick();
    idle();
    check("full_no_issue", bus.au_valid, 0);
    for (int t = 7; t >= 4; t--) begin
      cdb(3'(t), 32'(t * 16));
      tick();
    end
    idle();
    check("wake_rev_no_issue", bus.au_valid, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("order_rob%0d", k), bus.au_rob, 32'(k));
      check($sformatf("order_val%0d", k), bus.au_value1, 32'((k + 3) * 16));
    end
    tick();
    check("fifth_dropped_valid", bus.au_valid, 0);
    check("fifth_dropped_rob", bus.au_rob, 0);
    check("empty_disp_ready", bus.disp_ready, 1);

    // Backpressure with four ready loads.
    bus.au_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      disp(3'(k), 1'b0, 32'(k * 32'h11), 3'd0, 1'b1, 32'(k), 32'h0, 3'd0, 1'b0);
      tick();
      if (k >= 2) check($sformatf("bp_hold_rob_e%0d", k), bus.au_rob, 1);
    end
    idle();
    tick();
    check("bp_hold_valid", bus.au_valid, 1);
    check("bp_hold_rob", bus.au_rob, 1);
    check("bp_hold_value1", bus.au_value1, 32'h11);
    check("bp_disp_ready", bus.disp_ready, 1);
    bus.au_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("b2b_valid%0d", k), bus.au_valid, 1);
      check($sformatf("b2b_rob%0d", k), bus.au_rob, 32'(k));
      check($sformatf("b2b_val%0d", k), bus.au_value1, 32'(k * 32'h11));
    end
    tick();
    check("b2b_drain", bus.au_valid, 0);

    // Dispatch-cycle bypass on base tag 2.
    disp(3'd6, 1'b0, 32'h0, 3'd2, 1'b0, 32'h4, 32'h0, 3'd0, 1'b0);
    cdb(3'd2, 32'h44);
    tick();
    idle();
    check("byp_not_yet", bus.au_valid, 0);
    tick();
    check("byp_valid", bus.au_valid, 1);
    check("byp_value1", bus.au_value1, 32'h44);
    check("byp_rob", bus.au_rob, 6);
    tick();

    // Flush with three queued entries, a full slot and a simultaneous dispatch.
    bus.au_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      disp(3'(k), 1'b0, 32'h70 + 32'(k), 3'd0, 1'b1, 32'h0, 32'h0, 3'd0, 1'b0);
      tick();
    end
    check("pre_flush_valid", bus.au_valid, 1);
    disp(3'd5, 1'b0, 32'h99, 3'd0, 1'b1, 32'h0, 32'h0, 3'd0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_valid", bus.au_valid, 0);
    check("flush_rob", bus.au_rob, 0);
    check("flush_value1", bus.au_value1, 0);
    check("flush_disp_ready", bus.disp_ready, 1);
    bus.au_ready = 1'b1;
    tick();
    tick();
    check("flush_empty_valid", bus.au_valid, 0);
    check("flush_empty_rob", bus.au_rob, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/au_issue_queue.md
Name: au_issue_queue

Overview:
- In-order load/store issue queue that sequences the address unit (AU).
- Accepts load/store micro-ops from dispatch, holds them until base (and store data) operands arrive on the CDB, then issues them one at a time in program order to the AU.
- Presents a registered valid/ready interface to the AU input stage; program order is preserved so memory ordering is never violated.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); width of the head/tail pointers.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (mispredict); clears the queue.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch this cycle.
- disp_op  in  5  load/store opcode, passed through to the AU.
- disp_is_store  in  1  1 = store (needs data operand), 0 = load.
- disp_rob  in  3  ROB tag; tag 0 is reserved for "no instruction".
- disp_base  in  32  base value, valid when disp_base_rdy=1.
- disp_base_tag  in  3  producer ROB tag when disp_base_rdy=0.
- disp_base_rdy  in  1  base operand available.
- disp_offset  in  32  immediate offset, always valid.
- disp_data  in  32  store data, valid when disp_data_rdy=1.
- disp_data_tag  in  3  producer tag of store data.
- disp_data_rdy  in  1  store data available; ignored for loads.
- cdb_valid  in  1  common-data-bus broadcast valid.
- cdb_rob  in  3  broadcast tag.
- cdb_value  in  32  broadcast value.
- au_valid  out  1  issue slot holds an op for the AU.
- au_ready  in  1  AU consumes the op this cycle.
- au_value1  out  32  base.
- au_value2  out  32  offset.
- au_op  out  5  opcode.
- au_rob  out  3  ROB tag; 0 when au_valid=0.
- au_ls_value  out  32  store data; 0 for loads.

Behaviour:
- Reset/flush (rst or flush high at posedge): clear count, head and tail pointers, and all entry valid bits; au_valid=0, au_rob=0, au_value1/au_value2/au_op/au_ls_value=0.
  - rst has priority over flush; flush has priority over dispatch, CDB and issue in the same cycle.
- disp_ready = (count != DEPTH), combinational from registered count. When full, no pass-through even if the head issues the same cycle.
- Dispatch (disp_valid && disp_ready) writes the entry at tail, then tail = tail+1 mod DEPTH (wraps).
  - For loads, the data operand is stored as ready with value 0.
- CDB wakeup: every valid entry whose base or data operand is not ready and whose tag equals cdb_rob (cdb_valid=1, cdb_rob!=0) captures cdb_value and becomes ready.
  - All matching entries update in the same cycle.
- Dispatch-cycle bypass: if cdb_valid, cdb_rob==disp_*_tag and disp_*_rdy=0, the entry is written already ready with cdb_value.
- Head is ready when it is valid, its base operand is ready, and (for stores) its data operand is ready.
- Issue slot load: at posedge, if the head is ready and (!au_valid || au_ready):
  - the head loads into the issue slot (au_valid=1, fields copied);
  - head = head+1 mod DEPTH;
  - the entry is invalidated.
- Issue slot hold: if au_valid && !au_ready, the slot holds all fields stable.
- Issue slot drain: if au_valid && au_ready and the head is not ready, au_valid=0 and au_rob=0.
- Simultaneous dispatch and issue: count unchanged.
- Latency:
  - dispatch with all operands ready at edge N -> au_valid at edge N+1 (if the queue and slot are free);
  - CDB wakeup of the head at edge N -> issue at edge N+1.
- Wakeup does not re-check entries already in the issue slot; only queue entries snoop the CDB.
- Strictly in-order: a ready younger entry never bypasses a non-ready head.

Test Plan:
- Reset then load dispatch: disp_rob=3, base ready=0x100, offset=0x8 -> next cycle au_valid=1, au_value1=0x100, au_value2=0x8, au_rob=3, au_ls_value=0.
- Store with base waiting on tag 5: no issue; cdb_valid, cdb_rob=5, cdb_value=0x2000 -> issue next cycle with au_value1=0x2000 and stored data intact.
- Fill 4 entries with heads not ready -> disp_ready=0, and a 5th dispatch is ignored. Wake entries in reverse order -> issue order is still 1,2,3,4, pointers wrap correctly, and 4 more dispatches are accepted.
- Backpressure: au_ready=0 for 3 cycles with au_valid=1 -> outputs stable. Raising au_ready with the next head ready -> back-to-back issue with no bubble.
- Dispatch-cycle bypass: dispatch a base tag 2 not ready while cdb_rob=2, cdb_value=0x44 in the same cycle -> issues next cycle with au_value1=0x44.
- Flush with 3 entries queued and au_valid=1, plus a simultaneous disp_valid -> next cycle count=0, au_valid=0, au_rob=0, the dispatch is dropped, disp_ready=1.
